// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline writes with buffered long-latency
// results onto the single register-file write port.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_wr_en_i,
  input  logic [4:0]  pipe_wr_reg_i,
  input  logic [31:0] pipe_wr_data_i,
  input  logic        ll_valid_i,
  output logic        ll_ready_o,
  input  logic [4:0]  ll_reg_i,
  input  logic [31:0] ll_data_i,
  output logic        wr_en_o,
  output logic [4:0]  wr_reg_o,
  output logic [31:0] wr_data_o,
  output logic        pipe_stall_o,
  output logic [31:0] pend_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_q;

  logic          pipe_real;
  logic          fifo_grant;
  logic          push;
  logic          pop;
  logic [31:0]   pend_raw;

  // Handshake-visible status depends only on registered state (and reset).
  assign busy_o       = !rst_i && (count != '0);
  assign ll_ready_o   = !rst_i && (count != CW'(DEPTH));
  assign pipe_stall_o = !rst_i && (starve_q == SW'(STARVE_MAX));

  assign pipe_real  = pipe_wr_en_i && (pipe_wr_reg_i != 5'd0);
  assign fifo_grant = busy_o && (!pipe_real || pipe_stall_o);
  assign pop        = fifo_grant;
  // Writes to x0 complete the handshake but never occupy an entry.
  assign push       = ll_valid_i && ll_ready_o && (ll_reg_i != 5'd0);

  always_comb begin
    wr_en_o   = 1'b0;
    wr_reg_o  = 5'd0;
    wr_data_o = 32'd0;
    if (fifo_grant) begin
      wr_en_o   = 1'b1;
      wr_reg_o  = reg_mem[rd_ptr];
      wr_data_o = data_mem[rd_ptr];
    end else if (pipe_real && !pipe_stall_o && !rst_i) begin
      wr_en_o   = 1'b1;
      wr_reg_o  = pipe_wr_reg_i;
      wr_data_o = pipe_wr_data_i;
    end
  end

  always_comb begin
    pend_raw = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        pend_raw[reg_mem[rd_ptr + AW'(i)]] = 1'b1;
      end
    end
  end

  assign pend_o = rst_i ? 32'd0 : pend_raw;

  always_ff @(posedge clk_i) begin
    if (push) begin
      reg_mem[wr_ptr]  <= ll_reg_i;
      data_mem[wr_ptr] <= ll_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      starve_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Saturates at STARVE_MAX; the forced grant then pops and clears it.
      if ((count == '0) || pop) begin
        starve_q <= '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, STARVE_MAX=4).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_en;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_reg;
  logic [31:0] ll_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        stall;
  logic [31:0] pend;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pipe_wr_en_i  (pipe_en),
    .pipe_wr_reg_i (pipe_reg),
    .pipe_wr_data_i(pipe_data),
    .ll_valid_i    (ll_valid),
    .ll_ready_o    (ll_ready),
    .ll_reg_i      (ll_reg),
    .ll_data_i     (ll_data),
    .wr_en_o       (wr_en),
    .wr_reg_o      (wr_reg),
    .wr_data_o     (wr_data),
    .pipe_stall_o  (stall),
    .pend_o        (pend),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pipe_en = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h1111_1111;
    ll_valid = 1'b0; ll_reg = 5'd0; ll_data = 32'd0;
    tick();
    #1;
    chk("rst_wr_en",    32'(wr_en), 0);
    chk("rst_ll_ready", 32'(ll_ready), 0);
    chk("rst_stall",    32'(stall), 0);
    chk("rst_pend",     pend, 0);
    chk("rst_busy",     32'(busy), 0);
    tick();

    // pipeline-only
    rst = 1'b0; pipe_en = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hDEADBEEF;
    #1;
    chk("pipe_wr_en",   32'(wr_en), 1);
    chk("pipe_wr_reg",  32'(wr_reg), 5);
    chk("pipe_wr_data", wr_data, 32'hDEADBEEF);
    chk("pipe_stall",   32'(stall), 0);
    chk("pipe_ready",   32'(ll_ready), 1);
    tick();

    // long-latency with idle pipeline
    pipe_en = 1'b0; ll_valid = 1'b1; ll_reg = 5'd7; ll_data = 32'h12345678;
    #1;
    chk("ll_c0_wr_en", 32'(wr_en), 0);
    tick();
    ll_valid = 1'b0;
    #1;
    chk("ll_c1_wr_en",   32'(wr_en), 1);
    chk("ll_c1_wr_reg",  32'(wr_reg), 7);
    chk("ll_c1_wr_data", wr_data, 32'h12345678);
    chk("ll_c1_pend",    pend, 32'h80);
    chk("ll_c1_busy",    32'(busy), 1);
    tick();
    #1;
    chk("ll_c2_pend",  pend, 0);
    chk("ll_c2_busy",  32'(busy), 0);
    chk("ll_c2_wr_en", 32'(wr_en), 0);

    // starvation
    pipe_en = 1'b1; pipe_reg = 5'd9; pipe_data = 32'h99;
    ll_valid = 1'b1; ll_reg = 5'd3; ll_data = 32'h33;
    #1;
    chk("stv_c0_wr_reg", 32'(wr_reg), 9);
    tick();
    ll_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("stv_c%0d_wr_reg", c), 32'(wr_reg), 9);
      chk($sformatf("stv_c%0d_stall", c), 32'(stall), 0);
      chk($sformatf("stv_c%0d_pend", c), pend, 32'h8);
      tick();
    end
    #1;
    chk("stv_c5_stall",   32'(stall), 1);
    chk("stv_c5_wr_reg",  32'(wr_reg), 3);
    chk("stv_c5_wr_data", wr_data, 32'h33);
    tick();
    #1;
    chk("stv_c6_stall",  32'(stall), 0);
    chk("stv_c6_wr_reg", 32'(wr_reg), 9);
    chk("stv_c6_busy",   32'(busy), 0);

    // full FIFO with continuous pipeline writes
    for (int r = 1; r <= 4; r++) begin
      ll_valid = 1'b1; ll_reg = 5'(r); ll_data = 32'h100 + 32'(r);
      #1;
      chk($sformatf("full_push%0d_ready", r), 32'(ll_ready), 1);
      tick();
    end
    ll_reg = 5'd5; ll_data = 32'h105;
    #1;
    chk("full_c4_ready",  32'(ll_ready), 0);
    chk("full_c4_wr_reg", 32'(wr_reg), 9);
    chk("full_c4_pend",   pend, 32'h1E);
    chk("full_c4_busy",   32'(busy), 1);
    tick();
    #1;
    chk("full_c5_stall",  32'(stall), 1);
    chk("full_c5_ready",  32'(ll_ready), 0);
    chk("full_c5_wr_reg", 32'(wr_reg), 1);
    chk("full_c5_data",   wr_data, 32'h101);
    tick();
    #1;
    chk("full_c6_ready",  32'(ll_ready), 1);
    chk("full_c6_stall",  32'(stall), 0);
    chk("full_c6_wr_reg", 32'(wr_reg), 9);
    chk("full_c6_pend",   pend, 32'h1C);
    tick();
    ll_valid = 1'b0; pipe_en = 1'b0;
    for (int r = 2; r <= 5; r++) begin
      #1;
      chk($sformatf("drain%0d_wr_en", r), 32'(wr_en), 1);
      chk($sformatf("drain%0d_wr_reg", r), 32'(wr_reg), 32'(r));
      chk($sformatf("drain%0d_data", r), wr_data, 32'h100 + 32'(r));
      tick();
    end
    #1;
    chk("drain_end_busy",  32'(busy), 0);
    chk("drain_end_wr_en", 32'(wr_en), 0);

    // x0 handling
    ll_valid = 1'b1; ll_reg = 5'd0; ll_data = 32'hBAD0;
    #1;
    chk("x0_ready", 32'(ll_ready), 1);
    tick();
    ll_valid = 1'b0;
    #1;
    chk("x0_busy",  32'(busy), 0);
    chk("x0_wr_en", 32'(wr_en), 0);
    chk("x0_pend",  pend, 0);
    ll_valid = 1'b1; ll_reg = 5'd6; ll_data = 32'h6666;
    tick();
    ll_valid = 1'b0; pipe_en = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hAAAA;
    #1;
    chk("x0pipe_wr_en",  32'(wr_en), 1);
    chk("x0pipe_wr_reg", 32'(wr_reg), 6);
    chk("x0pipe_data",   wr_data, 32'h6666);
    tick();
    #1;
    chk("x0pipe_busy", 32'(busy), 0);

    // reset mid-operation with three buffered entries
    pipe_reg = 5'd9; pipe_data = 32'h99;
    for (int r = 10; r <= 12; r++) begin
      ll_valid = 1'b1; ll_reg = 5'(r); ll_data = 32'h200 + 32'(r);
      tick();
    end
    ll_valid = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_pend", pend, 32'h1C00);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_pend",  pend, 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_ready", 32'(ll_ready), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    tick();
    rst = 1'b0; pipe_en = 1'b0;
    #1;
    chk("post_rst_busy",  32'(busy), 0);
    chk("post_rst_pend",  pend, 0);
    chk("post_rst_wr_en", 32'(wr_en), 0);
    chk("post_rst_ready", 32'(ll_ready), 1);
    tick();
    #1;
    chk("post_rst2_wr_en", 32'(wr_en), 0);
    chk("post_rst2_busy",  32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
